// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the register-file write-back path: write-enable
// encodings, zero-register indices and the queued write-back entry layout.
package writeback_arbiter_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  localparam logic [1:0] REGWRITE_NONE = 2'b00;
  localparam logic [1:0] REGWRITE_INT  = 2'b01;
  localparam logic [1:0] REGWRITE_FPU  = 2'b10;

  localparam logic [REG_W-1:0] INT_ZERO_REG = 5'd0;
  localparam logic [REG_W-1:0] FPU_ZERO_REG = 5'd30;

  typedef struct packed {
    logic             fpuSel;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_MEM,
    GNT_FPU,
    GNT_ALU
  } grant_e;

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// Load-result FIFO: absorbs un-stallable load pulses until the arbiter pops
// them; a push while full without a pop is dropped and flagged permanently.
module wb_load_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_push,
  input  wb_entry_t                  i_entry,
  input  logic                       i_pop,
  output wb_entry_t                  o_head,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_wrPtr;
  logic [PW-1:0]     r_rdPtr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic              w_full;
  logic              w_doPop;
  logic              w_doPush;

  assign w_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the simultaneous push needs.
  assign w_doPush = i_push && (!w_full || w_doPop);

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_entry;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PW'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (i_push && !w_doPush) r_overflow <= 1'b1;
    end
  end

  assign o_head     = r_mem[r_rdPtr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-back arbiter: one write per cycle chosen among queued
// loads, FPU and ALU, with starvation promotion and a registered write port.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int               XLEN           = writeback_arbiter_pkg::XLEN,
  parameter int               REG_W          = writeback_arbiter_pkg::REG_W,
  parameter int               MEM_FIFO_DEPTH = 2,
  parameter int               STARVE_LIMIT   = 4,
  parameter logic [REG_W-1:0] FPU_ZERO_REG   = writeback_arbiter_pkg::FPU_ZERO_REG
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [REG_W-1:0] alu_rd,
  input  logic             alu_fpu,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             fpu_valid,
  output logic             fpu_ready,
  input  logic [REG_W-1:0] fpu_rd,
  input  logic             fpu_fpu,
  input  logic [XLEN-1:0]  fpu_data,
  input  logic             data_ready_mem,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_fpu,
  input  logic [XLEN-1:0]  mem_data,
  output logic             mem_full,
  output logic [REG_W-1:0] rd_wb,
  output logic [XLEN-1:0]  write_data_register_wb,
  output logic [1:0]       regwrite_wb,
  output logic             wb_overflow
);

  localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam int                FCW     = $clog2(MEM_FIFO_DEPTH + 1);

  grant_e           w_grant;
  wb_entry_t        w_sel;
  wb_entry_t        w_head;
  wb_entry_t        w_push;
  logic             w_headEmpty;
  logic [FCW-1:0]   w_count;
  logic             w_zeroDest;
  logic [CNT_W-1:0] r_cntAlu;
  logic [CNT_W-1:0] r_cntFpu;
  logic [REG_W-1:0] r_rd;
  logic [XLEN-1:0]  r_data;
  logic [1:0]       r_regwrite;

  assign w_push = '{fpuSel: mem_fpu, rd: mem_rd, data: mem_data};

  wb_load_fifo #(.DEPTH(MEM_FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .i_push    (data_ready_mem),
    .i_entry   (w_push),
    .i_pop     (w_grant == GNT_MEM),
    .o_head    (w_head),
    .o_empty   (w_headEmpty),
    .o_count   (w_count),
    .o_overflow(wb_overflow)
  );

  assign mem_full = (w_count == FCW'(MEM_FIFO_DEPTH));

  // Starved sources jump the queue; otherwise loads win because they cannot wait.
  always_comb begin
    w_grant = GNT_NONE;
    if (alu_valid && (r_cntAlu >= LIMIT_C))      w_grant = GNT_ALU;
    else if (fpu_valid && (r_cntFpu >= LIMIT_C)) w_grant = GNT_FPU;
    else if (!w_headEmpty)                       w_grant = GNT_MEM;
    else if (fpu_valid)                          w_grant = GNT_FPU;
    else if (alu_valid)                          w_grant = GNT_ALU;
  end

  always_comb begin
    w_sel = '0;
    case (w_grant)
      GNT_MEM: w_sel = w_head;
      GNT_FPU: w_sel = '{fpuSel: fpu_fpu, rd: fpu_rd, data: fpu_data};
      GNT_ALU: w_sel = '{fpuSel: alu_fpu, rd: alu_rd, data: alu_data};
      default: w_sel = '0;
    endcase
  end

  assign alu_ready  = (w_grant == GNT_ALU);
  assign fpu_ready  = (w_grant == GNT_FPU);
  assign w_zeroDest = w_sel.fpuSel ? (w_sel.rd == FPU_ZERO_REG) : (w_sel.rd == INT_ZERO_REG);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cntAlu <= '0;
      r_cntFpu <= '0;
    end else begin
      if (alu_valid && (w_grant != GNT_ALU))
        r_cntAlu <= (r_cntAlu == LIMIT_C) ? r_cntAlu : r_cntAlu + CNT_W'(1);
      else
        r_cntAlu <= '0;
      if (fpu_valid && (w_grant != GNT_FPU))
        r_cntFpu <= (r_cntFpu == LIMIT_C) ? r_cntFpu : r_cntFpu + CNT_W'(1);
      else
        r_cntFpu <= '0;
    end
  end

  // Zero-register writes still consume the handshake but never enable the file.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd       <= '0;
      r_data     <= '0;
      r_regwrite <= REGWRITE_NONE;
    end else if (w_grant != GNT_NONE) begin
      r_rd       <= w_sel.rd;
      r_data     <= w_sel.data;
      r_regwrite <= w_zeroDest ? REGWRITE_NONE : (w_sel.fpuSel ? REGWRITE_FPU : REGWRITE_INT);
    end else begin
      r_regwrite <= REGWRITE_NONE;
    end
  end

  assign rd_wb                  = r_rd;
  assign write_data_register_wb = r_data;
  assign regwrite_wb            = r_regwrite;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter: a single-cycle vector
// table plus hand-traced load-queue, starvation, overflow and reset sequences.
module tb_writeback_arbiter;

  logic        clk;
  logic        rstn;
  logic        alu_valid, alu_ready, alu_fpu;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        fpu_valid, fpu_ready, fpu_fpu;
  logic [4:0]  fpu_rd;
  logic [31:0] fpu_data;
  logic        data_ready_mem, mem_fpu, mem_full;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic [4:0]  rd_wb;
  logic [31:0] write_data_register_wb;
  logic [1:0]  regwrite_wb;
  logic        wb_overflow;

  int checks   = 0;
  int failures = 0;

  writeback_arbiter dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .alu_valid             (alu_valid),
    .alu_ready             (alu_ready),
    .alu_rd                (alu_rd),
    .alu_fpu               (alu_fpu),
    .alu_data              (alu_data),
    .fpu_valid             (fpu_valid),
    .fpu_ready             (fpu_ready),
    .fpu_rd                (fpu_rd),
    .fpu_fpu               (fpu_fpu),
    .fpu_data              (fpu_data),
    .data_ready_mem        (data_ready_mem),
    .mem_rd                (mem_rd),
    .mem_fpu               (mem_fpu),
    .mem_data              (mem_data),
    .mem_full              (mem_full),
    .rd_wb                 (rd_wb),
    .write_data_register_wb(write_data_register_wb),
    .regwrite_wb           (regwrite_wb),
    .wb_overflow           (wb_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        aluValid;
    logic [4:0]  aluRd;
    logic        aluFpu;
    logic [31:0] aluData;
    logic        fpuValid;
    logic [4:0]  fpuRd;
    logic        fpuFpu;
    logic [31:0] fpuData;
    logic        expAluReady;
    logic        expFpuReady;
    logic [1:0]  expRw;
    logic        chkRdData;
    logic [4:0]  expRd;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    alu_valid = 1'b0; alu_rd = '0; alu_fpu = 1'b0; alu_data = '0;
    fpu_valid = 1'b0; fpu_rd = '0; fpu_fpu = 1'b0; fpu_data = '0;
    data_ready_mem = 1'b0; mem_rd = '0; mem_fpu = 1'b0; mem_data = '0;
  endtask

  task automatic doReset();
    rstn = 1'b0;
    clearInputs();
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    alu_valid = v.aluValid; alu_rd = v.aluRd; alu_fpu = v.aluFpu; alu_data = v.aluData;
    fpu_valid = v.fpuValid; fpu_rd = v.fpuRd; fpu_fpu = v.fpuFpu; fpu_data = v.fpuData;
    #3;
    checkOutput($sformatf("vec%0d_alu_ready", idx), alu_ready, v.expAluReady);
    checkOutput($sformatf("vec%0d_fpu_ready", idx), fpu_ready, v.expFpuReady);
    tick();
    checkOutput($sformatf("vec%0d_regwrite", idx), regwrite_wb, v.expRw);
    if (v.chkRdData) begin
      checkOutput($sformatf("vec%0d_rd", idx), rd_wb, v.expRd);
      checkOutput($sformatf("vec%0d_data", idx), write_data_register_wb, v.expData);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd5,  1'b0, 32'h1234, 1'b0, 5'd0,  1'b0, 32'h0,    1'b1, 1'b0, 2'b01, 1'b1, 5'd5,  32'h1234};
    vecs[1]  = '{1'b0, 5'd0,  1'b0, 32'h0,    1'b1, 5'd7,  1'b1, 32'hBEEF, 1'b0, 1'b1, 2'b10, 1'b1, 5'd7,  32'hBEEF};
    vecs[2]  = '{1'b1, 5'd1,  1'b0, 32'h11,   1'b1, 5'd2,  1'b1, 32'h22,   1'b0, 1'b1, 2'b10, 1'b1, 5'd2,  32'h22};
    vecs[3]  = '{1'b1, 5'd9,  1'b1, 32'h99,   1'b0, 5'd0,  1'b0, 32'h0,    1'b1, 1'b0, 2'b10, 1'b1, 5'd9,  32'h99};
    vecs[4]  = '{1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 1'b0, 2'b00, 1'b1, 5'd9,  32'h99};
    vecs[5]  = '{1'b1, 5'd0,  1'b0, 32'h55,   1'b0, 5'd0,  1'b0, 32'h0,    1'b1, 1'b0, 2'b00, 1'b0, 5'd0,  32'h0};
    vecs[6]  = '{1'b0, 5'd0,  1'b0, 32'h0,    1'b1, 5'd30, 1'b1, 32'h66,   1'b0, 1'b1, 2'b00, 1'b0, 5'd0,  32'h0};
    vecs[7]  = '{1'b1, 5'd30, 1'b0, 32'h30,   1'b0, 5'd0,  1'b0, 32'h0,    1'b1, 1'b0, 2'b01, 1'b1, 5'd30, 32'h30};
    vecs[8]  = '{1'b0, 5'd0,  1'b0, 32'h0,    1'b1, 5'd0,  1'b1, 32'h77,   1'b0, 1'b1, 2'b10, 1'b1, 5'd0,  32'h77};
    vecs[9]  = '{1'b0, 5'd0,  1'b0, 32'h0,    1'b1, 5'd3,  1'b0, 32'h88,   1'b0, 1'b1, 2'b01, 1'b1, 5'd3,  32'h88};
    vecs[10] = '{1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 5'd0,  1'b0, 32'h0,    1'b0, 1'b0, 2'b00, 1'b1, 5'd3,  32'h88};

    clearInputs();
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    checkOutput("reset_regwrite", regwrite_wb, 2'b00);
    checkOutput("reset_rd", rd_wb, 5'd0);
    checkOutput("reset_data", write_data_register_wb, 32'h0);
    checkOutput("reset_mem_full", mem_full, 1'b0);
    checkOutput("reset_overflow", wb_overflow, 1'b0);
    checkOutput("reset_alu_ready", alu_ready, 1'b0);
    checkOutput("reset_fpu_ready", fpu_ready, 1'b0);
    tick();
    tick();
    rstn = 1'b1;

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);
    clearInputs();

    // Queued load beats FPU; a pushed load is not visible in its push cycle.
    data_ready_mem = 1'b1; mem_rd = 5'd3; mem_fpu = 1'b1; mem_data = 32'hAAAA;
    tick();
    data_ready_mem = 1'b0;
    checkOutput("conflict_no_bypass", regwrite_wb, 2'b00);
    fpu_valid = 1'b1; fpu_rd = 5'd12; fpu_fpu = 1'b1; fpu_data = 32'hF00D;
    #3 checkOutput("conflict_fpu_wait", fpu_ready, 1'b0);
    tick();
    checkOutput("conflict_load_rw", regwrite_wb, 2'b10);
    checkOutput("conflict_load_rd", rd_wb, 5'd3);
    checkOutput("conflict_load_data", write_data_register_wb, 32'hAAAA);
    #3 checkOutput("conflict_fpu_ready", fpu_ready, 1'b1);
    tick();
    fpu_valid = 1'b0;
    checkOutput("conflict_fpu_rd", rd_wb, 5'd12);
    checkOutput("conflict_fpu_data", write_data_register_wb, 32'hF00D);
    checkOutput("conflict_fpu_rw", regwrite_wb, 2'b10);

    // Starvation: loads arrive every cycle, ALU wins on its fifth waiting cycle.
    doReset();
    data_ready_mem = 1'b1; mem_rd = 5'd4; mem_fpu = 1'b0; mem_data = 32'd0;
    tick();
    for (int i = 1; i <= 6; i++) begin
      mem_data  = 32'(i);
      alu_valid = (i <= 5); alu_rd = 5'd8; alu_fpu = 1'b0; alu_data = 32'hA1;
      #3 checkOutput($sformatf("starve_alu_ready_c%0d", i), alu_ready, (i == 5));
      tick();
      if (i < 5) begin
        checkOutput($sformatf("starve_load_data_c%0d", i), write_data_register_wb, 32'(i - 1));
      end else if (i == 5) begin
        checkOutput("starve_alu_rd", rd_wb, 5'd8);
        checkOutput("starve_alu_data", write_data_register_wb, 32'hA1);
      end else begin
        checkOutput("starve_resume_load", write_data_register_wb, 32'd4);
      end
      checkOutput($sformatf("starve_rw_c%0d", i), regwrite_wb, 2'b01);
    end
    checkOutput("starve_full_pushpop", mem_full, 1'b1);
    checkOutput("starve_no_overflow", wb_overflow, 1'b0);

    // Overflow: ALU/FPU promotions block pops while the queue is full.
    doReset();
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hC0;
    fpu_valid = 1'b1; fpu_rd = 5'd11; fpu_fpu = 1'b1; fpu_data = 32'hD0;
    mem_rd = 5'd6; mem_fpu = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      data_ready_mem = (c != 5);
      mem_data = 32'(100 + c);
      #3;
      checkOutput($sformatf("ovf_alu_ready_c%0d", c), alu_ready, (c == 4 || c == 9));
      checkOutput($sformatf("ovf_fpu_ready_c%0d", c), fpu_ready, (c == 0 || c == 5));
      tick();
      checkOutput($sformatf("ovf_full_c%0d", c), mem_full, (c >= 4));
      checkOutput($sformatf("ovf_flag_c%0d", c), wb_overflow, (c == 9));
    end

    // Asynchronous reset in the middle of traffic, away from any clock edge.
    data_ready_mem = 1'b1;
    #1 rstn = 1'b0;
    #1;
    checkOutput("midreset_regwrite", regwrite_wb, 2'b00);
    checkOutput("midreset_mem_full", mem_full, 1'b0);
    checkOutput("midreset_overflow", wb_overflow, 1'b0);
    checkOutput("midreset_rd", rd_wb, 5'd0);
    clearInputs();
    tick();
    rstn = 1'b1;
    tick();
    checkOutput("postreset_fifo_discarded", regwrite_wb, 2'b00);
    checkOutput("postreset_not_full", mem_full, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
